// File: rtl/frogger_game_if.sv
// Player/obstacle inputs and game-state outputs of the Frogger game controller.
// The controller is the slave; the player/display side is the master.
interface frogger_game_if #(
  parameter int COLS = 20,
  parameter int ROWS = 15
);
  logic                 start;
  logic                 tick;
  logic [COLS-1:0]      player_x;
  logic [ROWS-1:0]      player_y;
  logic [ROWS*COLS-1:0] rows;
  logic [1:0]           state;
  logic [3:0]           p1_score;
  logic [3:0]           p2_score;
  logic                 respawn;
  logic [1:0]           winner;

  modport master (
    output start, tick, player_x, player_y, rows,
    input  state, p1_score, p2_score, respawn, winner
  );

  modport slave (
    input  start, tick, player_x, player_y, rows,
    output state, p1_score, p2_score, respawn, winner
  );
endinterface

// File: rtl/frogger_game_ctrl.sv
// Two-player Frogger turn/score controller: collision and goal detection, turn FSM, respawn pulse.
// Optional per-turn timeout is enabled with the macro GAME_TIMEOUT_EN.
module frogger_game_ctrl #(
  parameter int COLS      = 20,
  parameter int ROWS      = 15,
  parameter int WIN_SCORE = 10
`ifdef GAME_TIMEOUT_EN
  , parameter int TURN_TICKS = 64
`endif
) (
  input logic           i_clk,
  input logic           i_reset,
  frogger_game_if.slave bus
);

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_t;

  localparam logic [3:0] WIN4   = 4'(WIN_SCORE);
  localparam logic [1:0] WIN_P1 = 2'b01;
  localparam logic [1:0] WIN_P2 = 2'b10;

  // Non-one-hot position vectors are evaluated bit by bit, so several set bits simply OR together.
  function automatic logic f_hit(input logic [ROWS-1:0] y, input logic [COLS-1:0] x,
                                 input logic [ROWS*COLS-1:0] obst);
    logic h;
    h = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      h = h | (y[r] & (|(obst[r*COLS +: COLS] & x)));
    end
    return h;
  endfunction

  state_t     r_state, w_state_nxt;
  logic [3:0] r_p1, w_p1_nxt, r_p2, w_p2_nxt;
  logic       r_respawn, w_respawn_nxt;
  logic [1:0] r_winner, w_winner_nxt;
  logic       r_start_d;
  logic       w_start_rise, w_hit, w_goal, w_timeout;
  logic [3:0] w_p1_inc, w_p2_inc;

  assign w_start_rise = bus.start & ~r_start_d;
  assign w_hit        = f_hit(bus.player_y, bus.player_x, bus.rows);
  assign w_goal       = bus.player_y[0];
  assign w_p1_inc     = r_p1 + 4'd1;
  assign w_p2_inc     = r_p2 + 4'd1;

`ifdef GAME_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_AT = 16'(TURN_TICKS - 1);
  logic [15:0] r_timer, w_timer_nxt;
  assign w_timeout = (r_timer == TIMEOUT_AT);
`else
  assign w_timeout = 1'b0;
`endif

  // Turn FSM, scores and respawn request; a goal always outranks a hit or a timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_p1_nxt      = r_p1;
    w_p2_nxt      = r_p2;
    w_respawn_nxt = 1'b0;
    w_winner_nxt  = r_winner;
    case (r_state)
      QI: begin
        if (w_start_rise) begin
          w_state_nxt   = QGAME_1;
          w_respawn_nxt = 1'b1;
        end else begin
          w_state_nxt = QI;
        end
      end
      QGAME_1: begin
        if (bus.tick && w_goal) begin
          w_p1_nxt      = w_p1_inc;
          w_respawn_nxt = 1'b1;
          if (w_p1_inc == WIN4) begin
            w_state_nxt  = QDONE;
            w_winner_nxt = WIN_P1;
          end else begin
            w_state_nxt = QGAME_1;
          end
        end else if (bus.tick && (w_hit || w_timeout)) begin
          w_state_nxt   = QGAME_2;
          w_respawn_nxt = 1'b1;
        end else begin
          w_state_nxt = QGAME_1;
        end
      end
      QGAME_2: begin
        if (bus.tick && w_goal) begin
          w_p2_nxt      = w_p2_inc;
          w_respawn_nxt = 1'b1;
          if (w_p2_inc == WIN4) begin
            w_state_nxt  = QDONE;
            w_winner_nxt = WIN_P2;
          end else begin
            w_state_nxt = QGAME_2;
          end
        end else if (bus.tick && (w_hit || w_timeout)) begin
          w_state_nxt   = QGAME_1;
          w_respawn_nxt = 1'b1;
        end else begin
          w_state_nxt = QGAME_2;
        end
      end
      QDONE: begin
        w_state_nxt = QDONE;
      end
      default: begin
        w_state_nxt = QI;
      end
    endcase
`ifdef GAME_TIMEOUT_EN
    if (w_respawn_nxt) begin
      w_timer_nxt = 16'd0;
    end else if (bus.tick && ((r_state == QGAME_1) || (r_state == QGAME_2))) begin
      w_timer_nxt = r_timer + 16'd1;
    end else begin
      w_timer_nxt = r_timer;
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= QI;
      r_p1      <= 4'd0;
      r_p2      <= 4'd0;
      r_respawn <= 1'b0;
      r_winner  <= 2'b00;
      r_start_d <= 1'b0;
`ifdef GAME_TIMEOUT_EN
      r_timer   <= 16'd0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_p1      <= w_p1_nxt;
      r_p2      <= w_p2_nxt;
      r_respawn <= w_respawn_nxt;
      r_winner  <= w_winner_nxt;
      r_start_d <= bus.start;
`ifdef GAME_TIMEOUT_EN
      r_timer   <= w_timer_nxt;
`endif
    end
  end

  assign bus.state    = r_state;
  assign bus.p1_score = r_p1;
  assign bus.p2_score = r_p2;
  assign bus.respawn  = r_respawn;
  assign bus.winner   = r_winner;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Self-checking bench for frogger_game_ctrl: vector table plus multi-cycle sequences, scoreboard queue.
module tb_frogger_game_ctrl;
  localparam int COLS = 20;
  localparam int ROWS = 15;

  typedef struct {
    logic                 reset;
    logic                 start;
    logic                 tick;
    logic [ROWS-1:0]      y;
    logic [COLS-1:0]      x;
    logic [ROWS*COLS-1:0] obst;
    logic [1:0]           st;
    logic [3:0]           p1;
    logic [3:0]           p2;
    logic                 resp;
    logic [1:0]           win;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  vec_t sb[$];
  vec_t tbl[15];

  logic [ROWS-1:0]      y_start, y_goal, y5;
  logic [COLS-1:0]      x3, x4;
  logic [ROWS*COLS-1:0] r_none, r53, r03;

  frogger_game_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  frogger_game_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .WIN_SCORE(10)
`ifdef GAME_TIMEOUT_EN
    , .TURN_TICKS(4)
`endif
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rs, input logic s, input logic t, input logic [ROWS-1:0] y,
                              input logic [COLS-1:0] x, input logic [ROWS*COLS-1:0] o,
                              input logic [1:0] st, input logic [3:0] p1, input logic [3:0] p2,
                              input logic resp, input logic [1:0] win);
    vec_t v;
    v.reset = rs; v.start = s; v.tick = t; v.y = y; v.x = x; v.obst = o;
    v.st = st; v.p1 = p1; v.p2 = p2; v.resp = resp; v.win = win;
    return v;
  endfunction

  // Drive one cycle of inputs, queue its expectation, and compare after the edge that samples it.
  task automatic step(input string tag, input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    rst          = v.reset;
    bus.start    = v.start;
    bus.tick     = v.tick;
    bus.player_y = v.y;
    bus.player_x = v.x;
    bus.rows     = v.obst;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".state"},   idx, 32'(bus.state),    32'(e.st));
    check({tag, ".p1"},      idx, 32'(bus.p1_score), 32'(e.p1));
    check({tag, ".p2"},      idx, 32'(bus.p2_score), 32'(e.p2));
    check({tag, ".respawn"}, idx, 32'(bus.respawn),  32'(e.resp));
    check({tag, ".winner"},  idx, 32'(bus.winner),   32'(e.win));
  endtask

  task automatic do_reset(input string tag, input logic s);
    for (int i = 0; i < 2; i++) begin
      step(tag, i, mk(1'b1, s, 1'b1, y_goal, x3, r03, 2'b00, 4'd0, 4'd0, 1'b0, 2'b00));
    end
  endtask

  initial begin
    y_start = '0; y_start[ROWS-1] = 1'b1;
    y_goal  = '0; y_goal[0] = 1'b1;
    y5      = '0; y5[5] = 1'b1;
    x3      = '0; x3[3] = 1'b1;
    x4      = '0; x4[4] = 1'b1;
    r_none  = '0;
    r53     = '0; r53[5*COLS+3] = 1'b1;
    r03     = '0; r03[3] = 1'b1;

    //              rst   start tick  y        x   rows    state  p1    p2    resp  win
    tbl[0]  = mk(1'b0, 1'b0, 1'b1, y_start, x3, r_none, 2'b00, 4'd0, 4'd0, 1'b0, 2'b00);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, y_goal,  x3, r_none, 2'b00, 4'd0, 4'd0, 1'b0, 2'b00);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, y_start, x3, r_none, 2'b01, 4'd0, 4'd0, 1'b1, 2'b00);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, y_start, x3, r_none, 2'b01, 4'd0, 4'd0, 1'b0, 2'b00);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, y_start, x3, r53,    2'b01, 4'd0, 4'd0, 1'b0, 2'b00);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, y5,      x3, r53,    2'b01, 4'd0, 4'd0, 1'b0, 2'b00);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, y5,      x3, r53,    2'b10, 4'd0, 4'd0, 1'b1, 2'b00);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, y5,      x4, r53,    2'b10, 4'd0, 4'd0, 1'b0, 2'b00);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, y_goal,  x3, r_none, 2'b10, 4'd0, 4'd1, 1'b1, 2'b00);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, y_goal,  x3, r03,    2'b10, 4'd0, 4'd2, 1'b1, 2'b00);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, y5,      x3, r53,    2'b01, 4'd0, 4'd2, 1'b1, 2'b00);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, '0,      '0, r53,    2'b01, 4'd0, 4'd2, 1'b0, 2'b00);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, y_start, x3, r_none, 2'b01, 4'd0, 4'd2, 1'b0, 2'b00);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, y_goal,  x3, r_none, 2'b01, 4'd1, 4'd2, 1'b1, 2'b00);
    tbl[14] = mk(1'b0, 1'b1, 1'b1, y_goal,  x3, r03,    2'b01, 4'd2, 4'd2, 1'b1, 2'b00);

    bus.start = 1'b0; bus.tick = 1'b0; bus.player_y = '0; bus.player_x = '0; bus.rows = '0;
    do_reset("rst0", 1'b0);
    for (int i = 0; i < 15; i++) begin
      step("tbl", i, tbl[i]);
    end

    // Reset mid-game with start held: start_d clears, so the held level counts as a new rising edge.
    do_reset("rst_mid", 1'b1);
    step("restart", 0, mk(1'b0, 1'b1, 1'b0, y_start, x3, r_none, 2'b01, 4'd0, 4'd0, 1'b1, 2'b00));
    for (int i = 1; i <= 10; i++) begin
      step("win1", i, mk(1'b0, 1'b1, 1'b1, y_goal, x3, r_none, (i == 10) ? 2'b11 : 2'b01,
                         4'(i), 4'd0, 1'b1, (i == 10) ? 2'b01 : 2'b00));
    end
    for (int i = 0; i < 4; i++) begin
      step("done", i, mk(1'b0, 1'(i % 2), 1'b1, y_goal, x3, r03, 2'b11, 4'd10, 4'd0, 1'b0, 2'b01));
    end

    // Reset out of QDONE, then goal+hit in QGAME_2 and a reset while inputs request a goal.
    do_reset("rst_done", 1'b0);
    step("g2", 0, mk(1'b0, 1'b1, 1'b0, y_start, x3, r_none, 2'b01, 4'd0, 4'd0, 1'b1, 2'b00));
    step("g2", 1, mk(1'b0, 1'b1, 1'b1, y5,      x3, r53,    2'b10, 4'd0, 4'd0, 1'b1, 2'b00));
    step("g2", 2, mk(1'b0, 1'b1, 1'b1, y_goal,  x3, r03,    2'b10, 4'd0, 4'd1, 1'b1, 2'b00));
    step("g2", 3, mk(1'b1, 1'b1, 1'b1, y_goal,  x3, r03,    2'b00, 4'd0, 4'd0, 1'b0, 2'b00));

    do_reset("rst_to", 1'b0);
    step("to", 0, mk(1'b0, 1'b1, 1'b0, y_start, x3, r_none, 2'b01, 4'd0, 4'd0, 1'b1, 2'b00));
`ifdef GAME_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      step("to1", i, mk(1'b0, 1'b1, 1'b1, y_start, x3, r_none, (i == 4) ? 2'b10 : 2'b01,
                        4'd0, 4'd0, 1'(i == 4), 2'b00));
    end
    for (int i = 1; i <= 3; i++) begin
      step("to2", i, mk(1'b0, 1'b1, 1'b1, y_start, x3, r_none, 2'b10, 4'd0, 4'd0, 1'b0, 2'b00));
    end
    step("to_goal", 0, mk(1'b0, 1'b1, 1'b1, y_goal, x3, r_none, 2'b10, 4'd0, 4'd1, 1'b1, 2'b00));
`else
    for (int i = 1; i <= 100; i++) begin
      step("noto", i, mk(1'b0, 1'b1, 1'b1, y_start, x3, r_none, 2'b01, 4'd0, 4'd0, 1'b0, 2'b00));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
